// File: rtl/booth_seq_mult_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier:
// controller states and Booth partial-product select codes.
package booth_seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM,
        SEL_P2M,
        SEL_NM,
        SEL_N2M
    } booth_sel_t;

    function automatic booth_sel_t booth_sel(
        input logic neg,
        input logic one,
        input logic two
    );
        booth_sel_t s;
        case ({neg, one, two})
            3'b010:  s = SEL_PM;
            3'b001:  s = SEL_P2M;
            3'b110:  s = SEL_NM;
            3'b101:  s = SEL_N2M;
            default: s = SEL_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_seq_mult_encoder.sv
// Radix-4 Booth triplet decoder: {q1, q0, q_-1} -> neg/one/two.
module booth_encoder (
    input  logic [2:0] triplet_i,
    output logic       neg_o,
    output logic       one_o,
    output logic       two_o
);

    // 111 is a zero digit, so it must not assert neg
    assign neg_o = triplet_i[2] & ~(triplet_i[1] & triplet_i[0]);
    assign one_o = triplet_i[1] ^ triplet_i[0];
    assign two_o = (triplet_i == 3'b011) | (triplet_i == 3'b100);

endmodule

// File: rtl/booth_seq_mult.sv
// Radix-4 Booth sequential signed multiplier: one digit per CALC
// cycle, N/2 digits, product latched on entry to DONE.
module booth_seq_mult
    import booth_seq_mult_pkg::*;
#(
    parameter int NUMBER_OF_BITS = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUMBER_OF_BITS-1:0]     multiplicand,
    input  logic [NUMBER_OF_BITS-1:0]     multiplier,
    output logic                          busy,
    output logic                          done,
    output logic [2*NUMBER_OF_BITS-1:0]   product
);

    localparam int N  = NUMBER_OF_BITS;
    localparam int CW = $clog2(N/2) + 1;
    localparam logic [CW-1:0] LAST = CW'(N/2);

    state_t          state_q, state_d;
    logic [N-1:0]    m_q, m_d;
    logic [N+1:0]    acc_q, acc_d;
    logic [N-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  product_q, product_d;

    logic            neg, one, two;
    booth_sel_t      sel;
    logic [N+1:0]    m_ext;
    logic [N+1:0]    addend;
    logic [N+1:0]    sum;

    booth_encoder u_enc (
        .triplet_i ({q_q[1:0], qm1_q}),
        .neg_o     (neg),
        .one_o     (one),
        .two_o     (two)
    );

    assign sel   = booth_sel(neg, one, two);
    assign m_ext = {{2{m_q[N-1]}}, m_q};

    always_comb begin
        addend = '0;
        case (sel)
            SEL_PM:  addend = m_ext;
            SEL_P2M: addend = m_ext << 1;
            SEL_NM:  addend = -m_ext;
            SEL_N2M: addend = -(m_ext << 1);
            default: addend = '0;
        endcase
    end

    assign sum = acc_q + addend;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // the terminal CALC cycle only retires the result
                if (cnt_q == LAST) begin
                    product_d = {acc_q[N-1:0], q_q};
                    state_d   = DONE;
                end else begin
                    acc_d = {{2{sum[N+1]}}, sum[N+1:2]};
                    q_d   = {sum[1:0], q_q[N-1:2]};
                    qm1_d = q_q[1];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
